// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master to one-slave bus arbiter.
//
// Each transaction is granted in IDLE or RESP. It drives the slave bus for one ISSUE cycle and
// is acknowledged to its master in the following RESP cycle. Under continuous requests this
// gives one transaction every two cycles.
//
// Configuration macro BUS_ARB_FIXED_PRIO_EN:
//   undefined - round-robin arbitration; on a tie, the master not granted last wins.
//   defined   - master 0 wins ties. After HOLD_MAX consecutive master-0 grants while
//               m1_req_i is high, master 1 wins the next arbitration.
//
// Parameters:
//   HOLD_MAX  - starvation limit for master 1 (fixed-priority build only)
// Ports:
//   clk, rst                    - clock; asynchronous active-high reset
//   m{0,1}_req_i                - request, held with its controls until ack
//   m{0,1}_wr_i                 - 1 = write, 0 = read
//   m{0,1}_addr_i, m{0,1}_data_i - address and write data
//   m{0,1}_ack_o                - one-cycle completion pulse
//   m{0,1}_data_o               - read data, valid with ack
//   s_rd_en_o, s_wr_en_o        - slave strobes, high only in ISSUE
//   s_addr_o, s_data_o          - slave address / write data
//   s_data_i                    - slave read data, valid the cycle after s_rd_en_o
module bus_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  input  logic        m1_req_i,
  input  logic        m0_wr_i,
  input  logic        m1_wr_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic [31:0] m1_data_i,
  output logic        m0_ack_o,
  output logic        m1_ack_o,
  output logic [31:0] m0_data_o,
  output logic [31:0] m1_data_o,
  output logic        s_rd_en_o,
  output logic        s_wr_en_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e state_q;
  logic   grant_q;  // master owning the current ISSUE/RESP pair
  logic   last_q;   // master granted most recently
  logic   armed_q;  // low for the first cycle after reset so ISSUE cannot follow release directly
  logic   arb_en;
  logic   win1;     // arbitration result: 1 = master 1, 0 = master 0

`ifdef BUS_ARB_FIXED_PRIO_EN
  localparam int unsigned HoldW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;
  logic [HoldW-1:0] hold_q;  // consecutive master-0 grants while master 1 waits

  assign win1 = m1_req_i & (~m0_req_i | (hold_q == HoldW'(HOLD_MAX)));
`else
  // HOLD_MAX only matters with fixed priority.
  logic unused_hold_max;
  assign unused_hold_max = ^HOLD_MAX;

  assign win1 = m1_req_i & (~m0_req_i | ~last_q);
`endif

  // No arbitration during ISSUE: the slave bus is busy with the granted access.
  assign arb_en = armed_q & (state_q != StIssue) & (m0_req_i | m1_req_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      armed_q <= 1'b0;
`ifdef BUS_ARB_FIXED_PRIO_EN
      hold_q  <= '0;
`endif
    end else begin
      armed_q <= 1'b1;
      unique case (state_q)
        StIdle, StResp: begin
          if (arb_en) begin
            state_q <= StIssue;
            grant_q <= win1;
            last_q  <= win1;
          end else begin
            state_q <= StIdle;
          end
        end
        StIssue: state_q <= StResp;
        default: state_q <= StIdle;
      endcase
`ifdef BUS_ARB_FIXED_PRIO_EN
      if (!m1_req_i) begin
        hold_q <= '0;
      end else if (arb_en) begin
        hold_q <= win1 ? '0 : hold_q + 1'b1;
      end
`endif
    end
  end

  // Slave bus: combinational view of the granted master during ISSUE only.
  always_comb begin
    s_rd_en_o = 1'b0;
    s_wr_en_o = 1'b0;
    s_addr_o  = '0;
    s_data_o  = '0;
    if (state_q == StIssue) begin
      if (grant_q) begin
        s_rd_en_o = ~m1_wr_i;
        s_wr_en_o = m1_wr_i;
        s_addr_o  = m1_addr_i;
        s_data_o  = m1_data_i;
      end else begin
        s_rd_en_o = ~m0_wr_i;
        s_wr_en_o = m0_wr_i;
        s_addr_o  = m0_addr_i;
        s_data_o  = m0_data_i;
      end
    end
  end

  // Response: ack and slave data to the granted master only.
  always_comb begin
    m0_ack_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m0_data_o = '0;
    m1_data_o = '0;
    if (state_q == StResp) begin
      if (grant_q) begin
        m1_ack_o  = 1'b1;
        m1_data_o = s_data_i;
      end else begin
        m0_ack_o  = 1'b1;
        m0_data_o = s_data_i;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized traffic. All outputs are checked every
// cycle against a transaction-level reference model of the arbiter.
module tb_bus_arbiter;

  localparam int unsigned HoldMax = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_i, m1_req_i, m0_wr_i, m1_wr_i;
  logic [31:0] m0_addr_i, m1_addr_i, m0_data_i, m1_data_i;
  logic        m0_ack_o, m1_ack_o;
  logic [31:0] m0_data_o, m1_data_o;
  logic        s_rd_en_o, s_wr_en_o;
  logic [31:0] s_addr_o, s_data_o;
  logic [31:0] s_data_i;

  bus_arbiter #(.HOLD_MAX(HoldMax)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req_i  (m0_req_i),
    .m1_req_i  (m1_req_i),
    .m0_wr_i   (m0_wr_i),
    .m1_wr_i   (m1_wr_i),
    .m0_addr_i (m0_addr_i),
    .m1_addr_i (m1_addr_i),
    .m0_data_i (m0_data_i),
    .m1_data_i (m1_data_i),
    .m0_ack_o  (m0_ack_o),
    .m1_ack_o  (m1_ack_o),
    .m0_data_o (m0_data_o),
    .m1_data_o (m1_data_o),
    .s_rd_en_o (s_rd_en_o),
    .s_wr_en_o (s_wr_en_o),
    .s_addr_o  (s_addr_o),
    .s_data_o  (s_data_o),
    .s_data_i  (s_data_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model, per cycle: which master (if any) owns the slave bus, which is being
  // answered, and whether a new grant may be made. -1 means nobody.
  int iss_m, resp_m, last_m, hold;
  bit armed;

  function automatic int pick(input bit r0, input bit r1);
`ifdef BUS_ARB_FIXED_PRIO_EN
    if (r1 && (hold >= HoldMax || !r0)) return 1;
    return r0 ? 0 : -1;
`else
    if (r0 && r1) return 1 - last_m;
    if (r1) return 1;
    return r0 ? 0 : -1;
`endif
  endfunction

  task automatic check_outputs();
    logic        e_rd, e_wr;
    logic [31:0] e_addr, e_data;
    e_rd = 0; e_wr = 0; e_addr = 0; e_data = 0;
    if (iss_m == 0) begin
      e_rd = !m0_wr_i; e_wr = m0_wr_i; e_addr = m0_addr_i; e_data = m0_data_i;
    end else if (iss_m == 1) begin
      e_rd = !m1_wr_i; e_wr = m1_wr_i; e_addr = m1_addr_i; e_data = m1_data_i;
    end
    check("s_rd_en", 32'(s_rd_en_o), 32'(e_rd));
    check("s_wr_en", 32'(s_wr_en_o), 32'(e_wr));
    check("s_addr", s_addr_o, e_addr);
    check("s_data", s_data_o, e_data);
    check("m0_ack", 32'(m0_ack_o), 32'(resp_m == 0));
    check("m1_ack", 32'(m1_ack_o), 32'(resp_m == 1));
    check("m0_data", m0_data_o, (resp_m == 0) ? s_data_i : 32'h0);
    check("m1_data", m1_data_o, (resp_m == 1) ? s_data_i : 32'h0);
  endtask

  // Advance the model across one rising edge using the inputs seen just before it.
  task automatic model_edge();
    int win;
    win = -1;
    if (armed && iss_m == -1 && (m0_req_i || m1_req_i)) win = pick(m0_req_i, m1_req_i);
`ifdef BUS_ARB_FIXED_PRIO_EN
    if (!m1_req_i || win == 1) hold = 0;
    else if (win == 0) hold++;
`endif
    if (win != -1) last_m = win;
    resp_m = iss_m;
    iss_m  = win;
    armed  = 1;
  endtask

  int          cyc = 0;
  int          ack_order[$];
  int          ack0_cyc[$];
  logic [31:0] last_ack_data;
  logic [31:0] last_wr_data;

  task automatic step();
    @(negedge clk);
    check_outputs();
    if (m0_ack_o) begin
      ack_order.push_back(0);
      ack0_cyc.push_back(cyc);
      last_ack_data = m0_data_o;
    end
    if (m1_ack_o) begin
      ack_order.push_back(1);
      last_ack_data = m1_data_o;
    end
    if (s_wr_en_o) last_wr_data = s_data_o;
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    iss_m = -1; resp_m = -1; last_m = 1; hold = 0; armed = 0;
  endtask

  // Called at posedge+1; holds reset across two edges and releases away from the edge.
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    m0_req_i = 0; m1_req_i = 0; m0_wr_i = 0; m1_wr_i = 0;
    m0_addr_i = 0; m1_addr_i = 0; m0_data_i = 0; m1_data_i = 0;
  endtask

  int c0;
  int n_m1_acks;

  initial begin
    idle_inputs();
    s_data_i = 32'h0;
    rst = 1'b1;
    model_reset();
    #2;
    do_reset();

    // Single read by m0, raised right at reset release: ISSUE waits for the second edge.
    m0_req_i = 1; m0_wr_i = 0; m0_addr_i = 32'h10; s_data_i = 32'hDEADBEEF;
    c0 = cyc; ack0_cyc.delete(); ack_order.delete();
    for (int i = 0; i < 8; i++) begin
      step();
      if (resp_m == 0) m0_req_i = 0;
    end
    check("rd_ack_count", 32'(ack0_cyc.size()), 32'd1);
    if (ack0_cyc.size() > 0) check("first_ack_latency", 32'(ack0_cyc[0] - c0), 32'd3);
    check("rd_data", last_ack_data, 32'hDEADBEEF);
    n_m1_acks = 0;
    foreach (ack_order[k]) if (ack_order[k] == 1) n_m1_acks++;
    check("rd_no_m1_ack", 32'(n_m1_acks), 32'd0);

    // Single write by m1.
    idle_inputs();
    m1_req_i = 1; m1_wr_i = 1; m1_addr_i = 32'h8000_0000; m1_data_i = 32'h55;
    ack_order.delete(); last_wr_data = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (resp_m == 1) m1_req_i = 0;
    end
    check("wr_ack_count", 32'(ack_order.size()), 32'd1);
    check("wr_slave_data", last_wr_data, 32'h55);

    // Back-to-back reads from m0: acks every two cycles with no idle gap.
    idle_inputs();
    m0_req_i = 1; m0_addr_i = 32'h20; s_data_i = 32'h1234_5678;
    c0 = cyc; ack0_cyc.delete();
    for (int i = 0; i < 7; i++) step();
    m0_req_i = 0;
    check("b2b_ack_count", 32'(ack0_cyc.size()), 32'd3);
    if (ack0_cyc.size() == 3) begin
      check("b2b_ack1", 32'(ack0_cyc[0] - c0), 32'd2);
      check("b2b_ack2", 32'(ack0_cyc[1] - c0), 32'd4);
      check("b2b_ack3", 32'(ack0_cyc[2] - c0), 32'd6);
    end
    for (int i = 0; i < 3; i++) step();

    // Both masters requesting continuously after a fresh reset.
    do_reset();
    m0_req_i = 1; m1_req_i = 1; m0_addr_i = 32'hA0; m1_addr_i = 32'hB0;
    ack_order.delete();
    for (int i = 0; i < 22; i++) step();
    idle_inputs();
    check("contend_ack_count", 32'(ack_order.size()), 32'd10);
    foreach (ack_order[k]) begin
`ifdef BUS_ARB_FIXED_PRIO_EN
      check($sformatf("prio_order%0d", k), 32'(ack_order[k]), 32'((k % 5) == 4));
`else
      check($sformatf("rr_order%0d", k), 32'(ack_order[k]), 32'(k % 2));
`endif
    end
    for (int i = 0; i < 3; i++) step();

    // Reset asserted during a write ISSUE: strobe drops at once, no ack afterwards.
    m0_req_i = 1; m0_wr_i = 1; m0_addr_i = 32'h44; m0_data_i = 32'h99;
    for (int i = 0; i < 6 && iss_m != 0; i++) step();
    check("wr_issue_reached", 32'(iss_m == 0), 32'd1);
    check("wr_before_rst", 32'(s_wr_en_o), 32'd1);
    rst = 1'b1;
    #1;
    check("wr_after_rst", 32'(s_wr_en_o), 32'd0);
    check("ack_after_rst", 32'(m0_ack_o), 32'd0);
    idle_inputs();
    do_reset();
    ack_order.delete();
    for (int i = 0; i < 3; i++) step();
    check("no_ack_after_rst", 32'(ack_order.size()), 32'd0);
    m0_req_i = 1; m1_req_i = 1;
    for (int i = 0; i < 5; i++) step();
    check("post_rst_ack_seen", 32'(ack_order.size() > 0), 32'd1);
    if (ack_order.size() > 0) check("post_rst_first_winner", 32'(ack_order[0]), 32'd0);

    // Randomized traffic, including requests that drop before or during their grant.
    for (int i = 0; i < 400; i++) begin
      m0_req_i  = ($urandom_range(3) != 0);
      m1_req_i  = ($urandom_range(3) != 0);
      m0_wr_i   = $urandom_range(1);
      m1_wr_i   = $urandom_range(1);
      m0_addr_i = $urandom;
      m1_addr_i = $urandom;
      m0_data_i = $urandom;
      m1_data_i = $urandom;
      s_data_i  = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
